// File: rtl/track_nav_ctrl.sv
// Line-follow / obstacle controller: debounces track sensors, steers via a FORWARD/TURN/SEARCH/HALT FSM,
// and drives a slew-limited speed command based on obstacle distance.
module track_nav_ctrl #(
   parameter int unsigned N_SENS     = 3,
   parameter int unsigned DIST_W     = 6,
   parameter int unsigned STOP_DIST  = 8,
   parameter int unsigned SLOW_DIST  = 20,
   parameter int unsigned SPD_W      = 10,
   parameter int unsigned SPD_FULL   = 800,
   parameter int unsigned SPD_SLOW   = 500,
   parameter int unsigned RAMP_STEP  = 16,
   parameter int unsigned TICK_DIV   = 100000,
   parameter int unsigned DEB_TICKS  = 3,
   parameter int unsigned LOST_TICKS = 500
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_SENS-1:0] track,
   input  logic [DIST_W-1:0] distance,
   output logic [1:0]        mode,
   output logic [SPD_W-1:0]  speed,
   output logic [2:0]        state,
   output logic              lost
);

   localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned DEB_W  = $clog2(DEB_TICKS + 1);
   localparam int unsigned LOST_W = $clog2(LOST_TICKS + 1);
   localparam int unsigned C_IDX  = N_SENS / 2;

   typedef enum logic [2:0] {
      FORWARD = 3'd0,
      TURN_L  = 3'd1,
      TURN_R  = 3'd2,
      SEARCH  = 3'd3,
      HALT    = 3'd4
   } state_t;

   state_t              state_q, state_nx;
   logic [TICK_W-1:0]   tick_cnt, tick_cnt_nx;
   logic [N_SENS-1:0]   line, line_nx;
   logic [DEB_W-1:0]    deb_cnt    [N_SENS];
   logic [DEB_W-1:0]    deb_cnt_nx [N_SENS];
   logic                last_left, last_left_nx;
   logic [LOST_W-1:0]   lost_cnt, lost_cnt_nx;
   logic [SPD_W-1:0]    speed_nx;
   logic [1:0]          mode_nx;
   logic                lost_nx;

   logic                tick;
   logic                l_on, c_on, r_on, any_on, blocked;
   logic [SPD_W-1:0]    target;
   logic [SPD_W:0]      ramp_sum;

   assign state = state_q;

   // Next-state, debounce, ramp and output decode; everything advances only on tick.
   always_comb begin
      tick_cnt_nx  = tick_cnt;
      line_nx      = line;
      deb_cnt_nx   = deb_cnt;
      state_nx     = state_q;
      last_left_nx = last_left;
      lost_cnt_nx  = lost_cnt;
      speed_nx     = speed;
      mode_nx      = mode;
      lost_nx      = lost;
      target       = '0;
      ramp_sum     = '0;

      tick    = (tick_cnt == TICK_W'(TICK_DIV - 1));
      l_on    = |line[N_SENS-1:C_IDX+1];
      c_on    = line[C_IDX];
      r_on    = |line[C_IDX-1:0];
      any_on  = l_on | c_on | r_on;
      blocked = (distance <= DIST_W'(STOP_DIST));

      tick_cnt_nx = tick ? '0 : tick_cnt + TICK_W'(1);

      if (tick) begin
         // FSM sees the debounced lines as registered before this tick
         unique case (state_q)
            FORWARD: begin
               if (!any_on)             state_nx = SEARCH;
               else if (r_on && !l_on)  state_nx = TURN_R;
               else if (l_on && !r_on)  state_nx = TURN_L;
            end
            TURN_L: begin
               if (!any_on)             state_nx = SEARCH;
               else if (c_on && !l_on)  state_nx = FORWARD;
            end
            TURN_R: begin
               if (!any_on)             state_nx = SEARCH;
               else if (c_on && !r_on)  state_nx = FORWARD;
            end
            SEARCH: begin
               if (any_on)              state_nx = FORWARD;
               else if (!blocked) begin
                  if (lost_cnt == LOST_W'(LOST_TICKS - 1)) state_nx = HALT;
                  else lost_cnt_nx = lost_cnt + LOST_W'(1);
               end
            end
            HALT:    state_nx = HALT;
            default: state_nx = FORWARD;
         endcase

         if (state_nx != SEARCH) lost_cnt_nx = '0;
         if (state_nx == TURN_L && state_q != TURN_L) last_left_nx = 1'b1;
         if (state_nx == TURN_R && state_q != TURN_R) last_left_nx = 1'b0;

         for (int i = 0; i < int'(N_SENS); i++) begin
            if (~track[i] == line[i]) begin
               deb_cnt_nx[i] = '0;
            end else if (deb_cnt[i] == DEB_W'(DEB_TICKS - 1)) begin
               line_nx[i]    = ~track[i];
               deb_cnt_nx[i] = '0;
            end else begin
               deb_cnt_nx[i] = deb_cnt[i] + DEB_W'(1);
            end
         end

         if (blocked || state_nx == HALT)
            target = '0;
         else if (distance <= DIST_W'(SLOW_DIST) || state_nx != FORWARD)
            target = SPD_W'(SPD_SLOW);
         else
            target = SPD_W'(SPD_FULL);

         // Accelerate by at most RAMP_STEP; deceleration is immediate
         ramp_sum = {1'b0, speed} + (SPD_W+1)'(RAMP_STEP);
         if (target > speed)
            speed_nx = (ramp_sum > {1'b0, target}) ? target : ramp_sum[SPD_W-1:0];
         else
            speed_nx = target;

         unique case (state_nx)
            FORWARD: mode_nx = 2'b11;
            TURN_L:  mode_nx = 2'b01;
            TURN_R:  mode_nx = 2'b10;
            SEARCH:  mode_nx = last_left_nx ? 2'b01 : 2'b10;
            HALT:    mode_nx = 2'b00;
            default: mode_nx = 2'b11;
         endcase

         lost_nx = (state_nx == HALT);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt  <= '0;
         line      <= '0;
         for (int i = 0; i < int'(N_SENS); i++) deb_cnt[i] <= '0;
         state_q   <= FORWARD;
         last_left <= 1'b0;
         lost_cnt  <= '0;
         speed     <= '0;
         mode      <= 2'b11;
         lost      <= 1'b0;
      end else begin
         tick_cnt  <= tick_cnt_nx;
         line      <= line_nx;
         deb_cnt   <= deb_cnt_nx;
         state_q   <= state_nx;
         last_left <= last_left_nx;
         lost_cnt  <= lost_cnt_nx;
         speed     <= speed_nx;
         mode      <= mode_nx;
         lost      <= lost_nx;
      end
   end

endmodule
